lbist_ctrl: RTL
===============

# lbist_ctrl

Logic-BIST controller between the top-level reset/test-mode drivers and the BIST-instrumented RISC-V core. While the core is held in reset, it runs a fixed number of pseudo-random patterns from an internal LFSR into the core inputs and compacts the core's response word in a MISR. It then compares the final signature with a golden value and raises a sticky `go_nogo_o` with a pass/fail verdict. The bench and boot logic wait on `go_nogo_o` before loading firmware and releasing the core reset.

## Interface
Parameters:
- `WIDTH`, 32: LFSR and MISR width in bits.
- `N_PATTERNS`, 1024: patterns applied in RUN; must be ≥1.
- `SETTLE_CYCLES`, 2: extra compaction cycles after the last pattern, for core pipeline latency; may be 0.
- `POLY`, 32'h8020_0003: Galois feedback polynomial, shared by LFSR and MISR.
- `SEED`, 32'hACE1_0001: LFSR load value; must be nonzero. Elaboration error if zero.
- `GOLDEN_SIG`, 32'h0: expected final MISR signature.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous and active-low.
- `start_i` in 1: level request to run BIST; sampled only in IDLE.
- `resp_i` in WIDTH: compacted core response word, sampled in RUN and FLUSH.
- `pattern_o` out WIDTH: current LFSR state, driven to the core inputs.
- `pattern_valid_o` out 1: high in RUN only.
- `busy_o` out 1: high in SEED, RUN, FLUSH and CHECK.
- `signature_o` out WIDTH: current MISR state.
- `go_nogo_o` out 1: test finished; sticky.
- `pass_o` out 1: valid when `go_nogo_o`=1. Set to 1 iff signature == GOLDEN_SIG.

## Operation
- FSM states: IDLE → SEED → RUN → FLUSH → CHECK → DONE.
  - IDLE: waits for `start_i`=1.
  - SEED: 1 cycle. LFSR ← SEED, MISR ← 0, pattern counter ← 0.
  - RUN: N_PATTERNS cycles.
    - Each cycle, LFSR advances: lfsr' = {lfsr[W-2:0],0} ^ (lfsr[W-1] ? POLY : 0).
    - MISR absorbs: misr' = {misr[W-2:0],0} ^ (misr[W-1] ? POLY : 0) ^ resp_i.
    - Counter increments. Exit when counter == N_PATTERNS-1.
  - FLUSH: SETTLE_CYCLES cycles. LFSR holds, MISR keeps absorbing. Skipped entirely when SETTLE_CYCLES=0 (RUN goes directly to CHECK).
  - CHECK: 1 cycle. Registers `pass_o` ← (misr == GOLDEN_SIG).
  - DONE: terminal. `go_nogo_o`=1, `pass_o` and `signature_o` frozen. `start_i` is ignored; only reset leaves DONE.
- Counter width: $clog2(max(N_PATTERNS,SETTLE_CYCLES)+1). The counter is reused for FLUSH and cleared on entry to FLUSH.
- `start_i` dropping mid-run has no effect; the run always completes.

## Timing
- All outputs are registered or decoded from the state register. No combinational path from `resp_i` to any output.
- Reset values: state IDLE, `pattern_o` = 0, `pattern_valid_o` = 0, `busy_o` = 0, `signature_o` = 0, `go_nogo_o` = 0, `pass_o` = 0.
- Edge numbering, with `start_i`=1 sampled in IDLE at edge 0:
  - SEED after edge 0.
  - RUN after edge 1, lasting through edge N_PATTERNS+1.
  - FLUSH through edge N_PATTERNS+1+SETTLE_CYCLES.
  - CHECK, then DONE after edge N_PATTERNS+2+SETTLE_CYCLES. `go_nogo_o` rises in that cycle.
- The MISR absorbs exactly N_PATTERNS+SETTLE_CYCLES words of `resp_i`.
- The first absorbed word is the one present during the first RUN cycle. `pattern_o` during that cycle equals SEED.
- Reset asserted in any state, including mid-RUN or in DONE, immediately returns all outputs to their reset values. A new run needs `start_i` again after reset release.

## Structure
- `lbist_pkg` holds:
  - the `lbist_state_e` enum;
  - default POLY, SEED and WIDTH constants;
  - a `galois_step(v, poly)` function, used by both LFSR and MISR.
- Sub-module `lbist_misr` (WIDTH, POLY): clear, enable, data in, signature out. The LFSR stays inline in the controller.
- Estimated size: ~180 lines of RTL.

## Test plan
- WIDTH=32, N_PATTERNS=4, SETTLE_CYCLES=2, `resp_i`=0, GOLDEN_SIG=0, start at edge 0:
  - `go_nogo_o` rises after edge 8, with `pass_o`=1 and `signature_o`=0;
  - `pattern_valid_o` is high for exactly 4 cycles.
- Same configuration with `resp_i`=32'h1 constant, GOLDEN_SIG=0:
  - `signature_o` = 32'h3F (6 absorptions, no MSB feedback);
  - `pass_o`=0, `go_nogo_o`=1.
- RUN check:
  - `pattern_o` sequence = SEED, galois_step(SEED), galois_step²(SEED), galois_step³(SEED);
  - `pattern_o` holds during FLUSH.
- Reset mid-run: assert `rst`=0 on the 3rd RUN cycle.
  - All outputs return to their reset values asynchronously.
  - After release with `start_i`=1, a full run produces the identical signature to an uninterrupted run.
- DONE stickiness:
  - toggling `start_i` and `resp_i` for 20 cycles after DONE leaves `go_nogo_o`, `pass_o` and `signature_o` unchanged.
- SETTLE_CYCLES=0, N_PATTERNS=1:
  - `go_nogo_o` rises after edge 3;
  - exactly one `resp_i` word is absorbed.

Source files
------------

// File: rtl/lbist_pkg.sv
// Shared types, default constants and the Galois shift step used by the LBIST LFSR and MISR.
package lbist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSeed,
    StRun,
    StFlush,
    StCheck,
    StDone
  } lbist_state_e;

  localparam int unsigned LbistWidth    = 32;
  // Widest register the shared step function can handle.
  localparam int unsigned LbistMaxWidth = 64;

  localparam logic [LbistWidth-1:0] LbistPoly = 32'h8020_0003;
  localparam logic [LbistWidth-1:0] LbistSeed = 32'hACE1_0001;

  // One Galois step on the low `width` bits: shift left, fold POLY back in when the MSB falls out.
  function automatic logic [LbistMaxWidth-1:0] galois_step(
    input logic [LbistMaxWidth-1:0] v,
    input logic [LbistMaxWidth-1:0] poly,
    input int unsigned              width
  );
    logic [LbistMaxWidth-1:0] mask;
    logic                     msb;
    mask = {LbistMaxWidth{1'b1}} >> (LbistMaxWidth - width);
    msb  = |(v & (LbistMaxWidth'(1) << (width - 1)));
    return ((v << 1) & mask) ^ (msb ? (poly & mask) : '0);
  endfunction

endpackage

// File: rtl/lbist_misr.sv
// Multiple-input signature register: compacts one response word per enabled cycle.
module lbist_misr
  import lbist_pkg::*;
#(
  parameter int unsigned      WIDTH = LbistWidth,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(LbistPoly)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_sig
);

  logic [WIDTH-1:0] r_sig;
  logic [WIDTH-1:0] w_step;

  assign w_step = WIDTH'(galois_step(LbistMaxWidth'(r_sig), LbistMaxWidth'(POLY), WIDTH));

  // Signature register: clear has priority over absorption.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sig <= '0;
    end else if (i_clear) begin
      r_sig <= '0;
    end else if (i_en) begin
      r_sig <= w_step ^ i_data;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/lbist_ctrl.sv
// Logic-BIST controller: drives LFSR patterns into the core, compacts responses, latches a verdict.
module lbist_ctrl
  import lbist_pkg::*;
#(
  parameter int unsigned      WIDTH         = LbistWidth,
  parameter int unsigned      N_PATTERNS    = 1024,
  parameter int unsigned      SETTLE_CYCLES = 2,
  parameter logic [WIDTH-1:0] POLY          = WIDTH'(LbistPoly),
  parameter logic [WIDTH-1:0] SEED          = WIDTH'(LbistSeed),
  parameter logic [WIDTH-1:0] GOLDEN_SIG    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] resp_i,
  output logic [WIDTH-1:0] pattern_o,
  output logic             pattern_valid_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] signature_o,
  output logic             go_nogo_o,
  output logic             pass_o
);

  localparam int unsigned CntMax = (N_PATTERNS > SETTLE_CYCLES) ? N_PATTERNS : SETTLE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] RunLast   = CntW'((N_PATTERNS > 0) ? N_PATTERNS - 1 : 0);
  localparam logic [CntW-1:0] FlushLast = CntW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  if (SEED == '0) begin : g_bad_seed
    $fatal(1, "lbist_ctrl: SEED must be nonzero");
  end
  if (N_PATTERNS < 1) begin : g_bad_npat
    $fatal(1, "lbist_ctrl: N_PATTERNS must be at least 1");
  end
  if (WIDTH > LbistMaxWidth || WIDTH < 2) begin : g_bad_width
    $fatal(1, "lbist_ctrl: WIDTH out of supported range");
  end

  lbist_state_e     r_state;
  logic [WIDTH-1:0] r_lfsr;
  logic [CntW-1:0]  r_cnt;
  logic             r_valid;
  logic             r_busy;
  logic             r_go;
  logic             r_pass;

  logic [WIDTH-1:0] w_lfsr_step;
  logic [WIDTH-1:0] w_sig;
  logic             w_misr_clear;
  logic             w_misr_en;

  assign w_lfsr_step = WIDTH'(galois_step(LbistMaxWidth'(r_lfsr), LbistMaxWidth'(POLY), WIDTH));

  // MISR is cleared while seeding and absorbs every RUN and FLUSH cycle.
  assign w_misr_clear = (r_state == StSeed);
  assign w_misr_en    = (r_state == StRun) || (r_state == StFlush);

  lbist_misr #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_misr (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_misr_clear),
    .i_en    (w_misr_en),
    .i_data  (resp_i),
    .o_sig   (w_sig)
  );

  // Sequencer FSM with inline LFSR, shared pattern/settle counter and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_lfsr  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_go    <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start_i) begin
            r_state <= StSeed;
            r_busy  <= 1'b1;
          end
        end
        StSeed: begin
          r_lfsr  <= SEED;
          r_cnt   <= '0;
          r_valid <= 1'b1;
          r_state <= StRun;
        end
        StRun: begin
          r_lfsr <= w_lfsr_step;
          if (r_cnt == RunLast) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_state <= (SETTLE_CYCLES == 0) ? StCheck : StFlush;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StFlush: begin
          // LFSR holds so the core sees a stable last pattern while its pipeline drains.
          if (r_cnt == FlushLast) begin
            r_state <= StCheck;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StCheck: begin
          r_pass  <= (w_sig == GOLDEN_SIG);
          r_busy  <= 1'b0;
          r_go    <= 1'b1;
          r_state <= StDone;
        end
        StDone: begin
          // Terminal until reset; start_i ignored.
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign pattern_o       = r_lfsr;
  assign pattern_valid_o = r_valid;
  assign busy_o          = r_busy;
  assign signature_o     = w_sig;
  assign go_nogo_o       = r_go;
  assign pass_o          = r_pass;

endmodule
